bkm_step_stats_checker: RTL
===========================

# bkm_step_stats_checker

Parametrised multi-channel step checker for BKM iteration verification. It compares NCH result lanes against testbench golden lanes every valid cycle and flags each lane as warning or error against programmable tolerances. It also keeps per-lane running min/max delta, saturating warning/error counters and a first-error capture. Statistics are read out one lane at a time through a request/acknowledge port. It sits in the bkm_step bench alongside the control/data step checkers and replaces their fixed two-lane, untracked delta handling.

## Interface
Parameters:
- W, 16, lane data width (two's complement)
- NCH, 4, number of checked lanes (1..16)
- WCNT, 16, width of sample/warning/error counters
- LOG2NCH, 2, width of lane select (must be ≥ clog2(NCH))

Ports:
- clk  in  1  clock
- arst  in  1  reset, asynchronous, active-high
- srst  in  1  synchronous clear, active-high
- enable  in  1  update enable
- valid  in  1  sample present on tb_np1/res_np1
- tb_np1  in  NCH*W  golden values, lane i at [i*W +: W]
- res_np1  in  NCH*W  DUT values, same packing
- tol_war  in  W  unsigned warning threshold
- tol_err  in  W  unsigned error threshold
- war  out  NCH  per-lane warning, registered
- err  out  NCH  per-lane error, registered
- delta  out  NCH*W  per-lane delta, registered
- any_err  out  1  sticky: some lane has erred since clear
- first_err_ch  out  LOG2NCH  lowest lane index of the first erring sample
- first_err_idx  out  WCNT  sample index of the first erring sample
- sample_cnt  out  WCNT  accepted samples, saturating
- rd_req  in  1  statistics read request
- rd_ch  in  LOG2NCH  lane to read
- rd_ack  out  1  read data valid, single-cycle pulse
- rd_bad  out  1  rd_ch ≥ NCH
- rd_max, rd_min  out  W  signed running max/min delta of lane
- rd_war_cnt, rd_err_cnt  out  WCNT  lane counters

## Operation
- Sample accepted when enable=1, valid=1, srst=0.
- delta_i = res_i − tb_i, modulo 2^W, interpreted signed.
- abs_i = |delta_i|. The most-negative value maps to 2^(W−1)−1.
- err_i = abs_i > tol_err.
- war_i = abs_i > tol_war and not err_i. Warning and error are mutually exclusive.
- If tol_war ≥ tol_err, no warnings are ever raised.
- Per lane, on each accepted sample:
  - First sample after clear loads min=max=delta.
  - Later samples update min only if delta < min (signed), and max only if delta > max (signed).
  - war_cnt/err_cnt increment on war/err and saturate at all-ones.
- sample_cnt increments per accepted sample and saturates.
- First-error capture, states CLEAN → FAILED:
  - CLEAN: on the first accepted sample with any err_i, go to FAILED, set any_err=1, latch first_err_ch = lowest erring lane and first_err_idx = sample_cnt before increment.
  - FAILED: held until srst/arst.
- Read port:
  - rd_req sampled each cycle regardless of enable.
  - Next cycle: rd_ack=1 with the lane's stats as they were before that edge. A concurrent update appears on the following read.
  - rd_ch ≥ NCH: rd_ack=1, rd_bad=1, data fields 0.
  - Back-to-back requests give back-to-back acks.
- srst: clears all stats, counters, flags and FSM (to CLEAN), and suppresses any pending rd_ack. Has priority over enable, valid and rd_req.
- enable=0 or valid=0: no stats update. war/err/delta hold their last values.

## Timing
- Reset values (arst or srst): war=0, err=0, delta=0, any_err=0, first_err_ch=0, first_err_idx=0, sample_cnt=0, rd_ack=0, rd_bad=0, rd_max=rd_min=0, rd_war_cnt=rd_err_cnt=0.
- All lane min/max reset to 0; first-sample flags set.
- war/err/delta: latency 1 cycle from the accepted sample.
- any_err/first_err_*: asserted in the same cycle as the err bit.
- Stats visible to a read issued the cycle after the updating sample; rd_ack arrives 1 cycle after rd_req.
- arst mid-read: rd_ack is never emitted.
- Counter wrap: none; all counters saturate.

## Test plan
- W=16, NCH=2, tol_war=2, tol_err=8. Samples lane0 deltas 0, +3, −9 → war=00,01,00 and err=00,00,01 on successive cycles; any_err=1, first_err_ch=0, first_err_idx=2.
- Lane1 deltas +5, −4, +7, then rd_req with rd_ch=1 → next cycle rd_ack=1, rd_max=7, rd_min=−4, rd_war_cnt=3, rd_err_cnt=0.
- res=0x8000, tb=0x0000 → delta=0x8000, abs saturated to 32767 → err=1. Same inputs with tol_err=0xFFFF → war=1.
- WCNT=4: 20 error samples → rd_err_cnt=15 and sample_cnt=15 (saturated).
- rd_req with rd_ch=3 (NCH=2) → rd_ack=1, rd_bad=1, all data 0. rd_req together with srst → no rd_ack.
- enable=0 with valid samples → stats unchanged, war/err/delta hold. srst after a failure → any_err=0 and a fresh first sample reloads min/max.

Source files
------------

// File: rtl/bkm_step_stats_checker.sv
// Multi-lane step checker: per-lane delta vs golden with warning/error tolerances,
// running min/max delta, saturating counters, first-error capture and a lane read port.
//
// state  | meaning
// CLEAN  | no erring sample accepted since clear
// FAILED | an erring sample was seen; first_err_* latched until srst/arst
module bkm_step_stats_checker #(
  parameter int W       = 16,
  parameter int NCH     = 4,
  parameter int WCNT    = 16,
  parameter int LOG2NCH = 2
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 srst,
  input  logic                 enable,
  input  logic                 valid,
  input  logic [NCH*W-1:0]     tb_np1,
  input  logic [NCH*W-1:0]     res_np1,
  input  logic [W-1:0]         tol_war,
  input  logic [W-1:0]         tol_err,
  output logic [NCH-1:0]       war,
  output logic [NCH-1:0]       err,
  output logic [NCH*W-1:0]     delta,
  output logic                 any_err,
  output logic [LOG2NCH-1:0]   first_err_ch,
  output logic [WCNT-1:0]      first_err_idx,
  output logic [WCNT-1:0]      sample_cnt,
  input  logic                 rd_req,
  input  logic [LOG2NCH-1:0]   rd_ch,
  output logic                 rd_ack,
  output logic                 rd_bad,
  output logic [W-1:0]         rd_max,
  output logic [W-1:0]         rd_min,
  output logic [WCNT-1:0]      rd_war_cnt,
  output logic [WCNT-1:0]      rd_err_cnt
);

  typedef enum logic {CLEAN, FAILED} state_t;
  state_t state_q, state_d;

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};

  logic signed [W-1:0] delta_c [NCH];
  logic        [W-1:0] abs_c   [NCH];
  logic [NCH-1:0]      war_c, err_c;
  logic [LOG2NCH-1:0]  low_err_c;
  logic                accept, capture;

  logic signed [W-1:0] min_q [NCH];
  logic signed [W-1:0] max_q [NCH];
  logic [WCNT-1:0]     war_cnt_q [NCH];
  logic [WCNT-1:0]     err_cnt_q [NCH];
  logic [NCH-1:0]      first_q;

  logic                rd_hit;
  logic [W-1:0]        sel_max, sel_min;
  logic [WCNT-1:0]     sel_war, sel_err;

  assign accept  = enable && valid && !srst;
  assign any_err = (state_q == FAILED);

  // Error wins over warning, so tol_war >= tol_err silences warnings by itself.
  always_comb begin
    war_c     = '0;
    err_c     = '0;
    low_err_c = '0;
    for (int i = 0; i < NCH; i++) begin
      delta_c[i] = res_np1[i*W +: W] - tb_np1[i*W +: W];
      if (delta_c[i] == MOST_NEG)
        abs_c[i] = MAX_POS;
      else if (delta_c[i][W-1])
        abs_c[i] = -delta_c[i];
      else
        abs_c[i] = delta_c[i];
      err_c[i] = abs_c[i] > tol_err;
      war_c[i] = (abs_c[i] > tol_war) && !err_c[i];
    end
    for (int i = NCH-1; i >= 0; i--)
      if (err_c[i]) low_err_c = LOG2NCH'(i);
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      CLEAN: if (accept && (|err_c)) begin
        state_d = FAILED;
        capture = 1'b1;
      end
      FAILED: state_d = FAILED;
      default: state_d = CLEAN;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= CLEAN;
      first_err_ch  <= '0;
      first_err_idx <= '0;
      sample_cnt    <= '0;
      war           <= '0;
      err           <= '0;
      delta         <= '0;
    end else if (srst) begin
      state_q       <= CLEAN;
      first_err_ch  <= '0;
      first_err_idx <= '0;
      sample_cnt    <= '0;
      war           <= '0;
      err           <= '0;
      delta         <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        first_err_ch  <= low_err_c;
        first_err_idx <= sample_cnt;
      end
      if (accept) begin
        if (sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
        war <= war_c;
        err <= err_c;
        for (int i = 0; i < NCH; i++) delta[i*W +: W] <= delta_c[i];
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      first_q <= '1;
      for (int i = 0; i < NCH; i++) begin
        min_q[i]     <= '0;
        max_q[i]     <= '0;
        war_cnt_q[i] <= '0;
        err_cnt_q[i] <= '0;
      end
    end else if (srst) begin
      first_q <= '1;
      for (int i = 0; i < NCH; i++) begin
        min_q[i]     <= '0;
        max_q[i]     <= '0;
        war_cnt_q[i] <= '0;
        err_cnt_q[i] <= '0;
      end
    end else if (accept) begin
      first_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (first_q[i]) begin
          min_q[i] <= delta_c[i];
          max_q[i] <= delta_c[i];
        end else begin
          if (delta_c[i] < min_q[i]) min_q[i] <= delta_c[i];
          if (delta_c[i] > max_q[i]) max_q[i] <= delta_c[i];
        end
        if (war_c[i] && war_cnt_q[i] != '1) war_cnt_q[i] <= war_cnt_q[i] + 1'b1;
        if (err_c[i] && err_cnt_q[i] != '1) err_cnt_q[i] <= err_cnt_q[i] + 1'b1;
      end
    end
  end

  // Unmatched lane selects leave the data at zero and flag rd_bad.
  always_comb begin
    rd_hit  = 1'b0;
    sel_max = '0;
    sel_min = '0;
    sel_war = '0;
    sel_err = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_ch == LOG2NCH'(i)) begin
        rd_hit  = 1'b1;
        sel_max = max_q[i];
        sel_min = min_q[i];
        sel_war = war_cnt_q[i];
        sel_err = err_cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rd_ack     <= 1'b0;
      rd_bad     <= 1'b0;
      rd_max     <= '0;
      rd_min     <= '0;
      rd_war_cnt <= '0;
      rd_err_cnt <= '0;
    end else if (srst) begin
      rd_ack     <= 1'b0;
      rd_bad     <= 1'b0;
      rd_max     <= '0;
      rd_min     <= '0;
      rd_war_cnt <= '0;
      rd_err_cnt <= '0;
    end else begin
      rd_ack <= rd_req;
      rd_bad <= rd_req && !rd_hit;
      if (rd_req) begin
        rd_max     <= sel_max;
        rd_min     <= sel_min;
        rd_war_cnt <= sel_war;
        rd_err_cnt <= sel_err;
      end
    end
  end

endmodule
